// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               execute-stage writeback and a late load/response unit. Late
//               responses are queued in a small FIFO; one source is granted
//               per cycle, with a starvation counter that force-grants the
//               execute stage after MAX_WAIT consecutive denied cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [4:0]              ex_rd,
    input  logic [31:0]             ex_data,
    output logic                    ex_ready,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_rd,
    input  logic [31:0]             ld_data,
    output logic                    ld_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [31:0]             rf_wdata,
    output logic [$clog2(DEPTH):0]  fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] c_full     = CW'(DEPTH);
    localparam logic [WW-1:0] c_max_wait = WW'(MAX_WAIT);

    // Late-response queue storage and bookkeeping
    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wait_cnt;

    logic          w_push;
    logic          w_force;
    logic          w_grant_ex;
    logic          w_grant_ld;
    logic          w_grant;
    logic [4:0]    w_sel_rd;
    logic [31:0]   w_sel_data;

    // Load acceptance depends only on current occupancy, never on a same-cycle pop
    assign ld_ready = !rst && (r_cnt != c_full);
    assign w_push   = ld_valid && ld_ready;
    assign fifo_cnt = r_cnt;
    assign ex_ready = w_grant_ex;

    // Single-winner grant: starved ex first, then oldest queued load, then ex
    always_comb begin
        w_force    = ex_valid && (r_wait_cnt == c_max_wait);
        w_grant_ex = 1'b0;
        w_grant_ld = 1'b0;
        if (!rst) begin
            if (w_force) begin
                w_grant_ex = 1'b1;
            end else if (r_cnt != '0) begin
                w_grant_ld = 1'b1;
            end else if (ex_valid) begin
                w_grant_ex = 1'b1;
            end
        end
        w_grant    = w_grant_ex || w_grant_ld;
        w_sel_rd   = w_grant_ex ? ex_rd   : r_mem_rd[r_rd_ptr];
        w_sel_data = w_grant_ex ? ex_data : r_mem_data[r_rd_ptr];
    end

    // Queue payload write; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ld_rd;
            r_mem_data[r_wr_ptr] <= ld_data;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_grant_ld) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_grant_ld})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Count consecutive denied ex cycles; any ex grant or idle ex restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_grant_ex || !ex_valid) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_max_wait) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
        end
    end

    // Registered write port; x0 grants complete the handshake but never write
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= w_grant && (w_sel_rd != 5'd0);
            if (w_grant) begin
                rf_rd    <= w_sel_rd;
                rf_wdata <= w_sel_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed self-checking bench for wb_port_arbiter with
//               hand-computed expectations (DEPTH=2, MAX_WAIT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_cnt;

    int n_checks;
    int n_fail;
    int li;
    int ei;

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_rd    (ex_rd),
        .ex_data  (ex_data),
        .ex_ready (ex_ready),
        .ld_valid (ld_valid),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .rf_we    (rf_we),
        .rf_rd    (rf_rd),
        .rf_wdata (rf_wdata),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive the current load/ex vectors from their running indices
    task automatic drive_streams;
        ld_valid = (li < 8);
        ld_rd    = 5'(8 + li);
        ld_data  = 32'hD000_0000 + 32'(li);
        ex_valid = (ei < 3);
        ex_rd    = 5'(20 + ei);
        ex_data  = 32'hE000_0000 + 32'(ei);
    endtask

    // One arbitration cycle: check handshakes before the edge, write port after
    task automatic cyc(input string tag, input logic e_exr, input logic e_ldr,
                       input logic [1:0] e_cnt, input logic [4:0] e_rd,
                       input logic [31:0] e_data);
        #1;
        chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(e_exr));
        chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(e_ldr));
        chk({tag, ".fifo_cnt"}, 32'(fifo_cnt), 32'(e_cnt));
        tick();
        chk({tag, ".rf_we"},    32'(rf_we),    32'd1);
        chk({tag, ".rf_rd"},    32'(rf_rd),    32'(e_rd));
        chk({tag, ".rf_wdata"}, rf_wdata,      e_data);
        if (ld_valid && e_ldr) li++;
        if (ex_valid && e_exr) ei++;
        drive_streams();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held two cycles with ex requesting
        rst = 1'b1; ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h5555;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        tick();
        chk("rst1.ex_ready", 32'(ex_ready), 32'd0);
        chk("rst1.ld_ready", 32'(ld_ready), 32'd0);
        chk("rst1.rf_we",    32'(rf_we),    32'd0);
        chk("rst1.fifo_cnt", 32'(fifo_cnt), 32'd0);
        tick();
        chk("rst2.ex_ready", 32'(ex_ready), 32'd0);
        chk("rst2.rf_rd",    32'(rf_rd),    32'd0);
        chk("rst2.rf_wdata", rf_wdata,      32'd0);

        // ex only
        rst = 1'b0;
        #1;
        chk("ex.ex_ready",   32'(ex_ready), 32'd1);
        chk("ex.rf_we_pre",  32'(rf_we),    32'd0);
        tick();
        chk("ex.rf_we",      32'(rf_we),    32'd1);
        chk("ex.rf_rd",      32'(rf_rd),    32'd5);
        chk("ex.rf_wdata",   rf_wdata,      32'h5555);

        // Collision: queued load wins over a fresh ex request
        ex_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1111;
        #1;
        chk("col.ld_ready",  32'(ld_ready), 32'd1);
        tick();
        chk("col.push_we",   32'(rf_we),    32'd0);
        chk("col.push_cnt",  32'(fifo_cnt), 32'd1);
        chk("col.hold_rd",   32'(rf_rd),    32'd5);
        ld_valid = 1'b0; ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h6666;
        #1;
        chk("col.ex_stall",  32'(ex_ready), 32'd0);
        tick();
        chk("col.ld_we",     32'(rf_we),    32'd1);
        chk("col.ld_rd",     32'(rf_rd),    32'd7);
        chk("col.ld_data",   rf_wdata,      32'h1111);
        chk("col.cnt0",      32'(fifo_cnt), 32'd0);
        chk("col.ex_ready",  32'(ex_ready), 32'd1);
        tick();
        chk("col.ex_rd",     32'(rf_rd),    32'd3);
        chk("col.ex_data",   rf_wdata,      32'h6666);
        ex_valid = 1'b0;
        tick();
        chk("idle.rf_we",    32'(rf_we),    32'd0);

        // Starvation, full FIFO and pointer wrap with continuous traffic
        li = 0; ei = 0;
        drive_streams();
        cyc("c0",  1'b1, 1'b1, 2'd0, 5'd20, 32'hE000_0000);
        cyc("c1",  1'b0, 1'b1, 2'd1, 5'd8,  32'hD000_0000);
        cyc("c2",  1'b0, 1'b1, 2'd1, 5'd9,  32'hD000_0001);
        cyc("c3",  1'b0, 1'b1, 2'd1, 5'd10, 32'hD000_0002);
        cyc("c4",  1'b1, 1'b1, 2'd1, 5'd21, 32'hE000_0001);
        cyc("c5",  1'b0, 1'b0, 2'd2, 5'd11, 32'hD000_0003);
        cyc("c6",  1'b0, 1'b1, 2'd1, 5'd12, 32'hD000_0004);
        cyc("c7",  1'b0, 1'b1, 2'd1, 5'd13, 32'hD000_0005);
        cyc("c8",  1'b1, 1'b1, 2'd1, 5'd22, 32'hE000_0002);
        cyc("c9",  1'b0, 1'b0, 2'd2, 5'd14, 32'hD000_0006);
        cyc("c10", 1'b0, 1'b1, 2'd1, 5'd15, 32'hD000_0007);
        chk("drain.cnt",     32'(fifo_cnt), 32'd0);
        tick();
        chk("drain.rf_we",   32'(rf_we),    32'd0);

        // x0 destination: handshake completes, no write
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h1234;
        #1;
        chk("x0.ex_ready",   32'(ex_ready), 32'd1);
        tick();
        chk("x0.rf_we",      32'(rf_we),    32'd0);
        chk("x0.rf_wdata",   rf_wdata,      32'h1234);

        // Fill to two entries, then reset mid-operation
        ex_rd = 5'd25; ex_data = 32'h2525;
        ld_valid = 1'b1; ld_rd = 5'd26; ld_data = 32'h2626;
        repeat (5) tick();
        chk("mrst.cnt2",     32'(fifo_cnt), 32'd2);
        rst = 1'b1; ex_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("mrst.ld_ready", 32'(ld_ready), 32'd0);
        tick();
        chk("mrst.cnt0",     32'(fifo_cnt), 32'd0);
        chk("mrst.rf_we",    32'(rf_we),    32'd0);
        rst = 1'b0;
        tick();
        chk("post.rf_we1",   32'(rf_we),    32'd0);
        tick();
        chk("post.rf_we2",   32'(rf_we),    32'd0);
        chk("post.cnt",      32'(fifo_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
